// File: rtl/light_show_controller_pkg.sv
// light_pkg: shared types and display constants for the LED bar sequencer.
// Holds the mode/run enums, seven-segment codes and the mode-advance helper.
package light_pkg;

   typedef enum logic [1:0] {
      BOUNCE = 2'd0,
      WRAP   = 2'd1,
      FILL   = 2'd2,
      BLINK  = 2'd3
   } mode_e;

   typedef enum logic {
      RUN   = 1'b0,
      PAUSE = 1'b1
   } run_e;

   // Segment order g..a, active-low.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_P     = 7'b0001100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      unique case (m)
         BOUNCE:  n = WRAP;
         WRAP:    n = FILL;
         FILL:    n = BLINK;
         default: n = BOUNCE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/light_show_controller_if.sv
// Board-side bundle of the sequencer: KEY/SW in, LEDR/HEX0/HEX1 out.
// master = board/stimulus side, slave = light_show_controller.
interface light_show_controller_if #(
   parameter int N_LEDS = 10
);
   logic [3:0]        KEY;
   logic [9:0]        SW;
   logic [N_LEDS-1:0] LEDR;
   logic [6:0]        HEX0;
   logic [6:0]        HEX1;

   modport master (
      output KEY, SW,
      input  LEDR, HEX0, HEX1
   );

   modport slave (
      input  KEY, SW,
      output LEDR, HEX0, HEX1
   );
endinterface

// File: rtl/light_show_controller_tick_gen.sv
// tick_gen: one-cycle tick every 2**TICK_BASE enabled clocks.
// Ports: clk, reset (sync, high), en (count/tick enable), clr (zero counter), tick.
module tick_gen #(
   parameter int TICK_BASE = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [TICK_BASE-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + TICK_BASE'(1);
      end
   end

   // Fires during the last count so the wrap edge is the tick edge.
   assign tick = en && (&cnt);

endmodule

// File: rtl/light_show_controller.sv
// light_show_controller: single-clock LED bar sequencer with four patterns.
// Ports: CLOCK_50, reset (sync, high), io (KEY/SW in, LEDR/HEX0/HEX1 out).
module light_show_controller
   import light_pkg::*;
#(
   parameter int TICK_BASE = 5,
   parameter int N_LEDS    = 10
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   light_show_controller_if.slave  io
);

   localparam int POS_W = $clog2(N_LEDS);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

   logic [3:0]       key_s1;
   logic [3:0]       key_s2;
   logic [3:0]       key_s3;
   logic [3:0]       press;
   mode_e            mode;
   run_e             run;
   logic [POS_W-1:0] pos;
   logic             dir_up;
   logic             phase;
   logic [2:0]       step_cnt;
   logic             tick;
   logic             step;
   logic             restart;

   // Press = falling edge of the synchronized level.
   assign press   = key_s3 & ~key_s2;
   assign restart = press[0] | press[3];
   assign step    = tick && (step_cnt >= io.SW[2:0]);

   tick_gen #(
      .TICK_BASE (TICK_BASE)
   ) u_tick (
      .clk   (CLOCK_50),
      .reset (reset),
      .en    (run == RUN),
      .clr   (restart),
      .tick  (tick)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         key_s1   <= 4'hF;
         key_s2   <= 4'hF;
         key_s3   <= 4'hF;
         mode     <= BOUNCE;
         run      <= RUN;
         pos      <= '0;
         dir_up   <= 1'b1;
         phase    <= 1'b1;
         step_cnt <= '0;
      end else begin
         key_s1 <= io.KEY;
         key_s2 <= key_s1;
         key_s3 <= key_s2;
         if (press[1]) begin
            run <= (run == RUN) ? PAUSE : RUN;
         end
         if (press[0]) begin
            mode <= next_mode(mode);
         end
         // Restart wins over a coincident step.
         if (restart) begin
            pos      <= '0;
            dir_up   <= 1'b1;
            phase    <= 1'b1;
            step_cnt <= '0;
         end else begin
            if (tick) begin
               step_cnt <= step ? 3'd0 : step_cnt + 3'd1;
            end
            if (step) begin
               unique case (mode)
                  BOUNCE: begin
                     if (dir_up) begin
                        if (pos == POS_MAX) begin
                           dir_up <= 1'b0;
                           pos    <= pos - POS_W'(1);
                        end else begin
                           pos <= pos + POS_W'(1);
                        end
                     end else if (pos == '0) begin
                        dir_up <= 1'b1;
                        pos    <= pos + POS_W'(1);
                     end else begin
                        pos <= pos - POS_W'(1);
                     end
                  end
                  WRAP, FILL: begin
                     pos <= (pos == POS_MAX) ? '0 : pos + POS_W'(1);
                  end
                  default: begin
                     phase <= ~phase;
                  end
               endcase
            end
         end
      end
   end

   logic [N_LEDS-1:0] onehot;
   logic [N_LEDS:0]   fill_w;
   logic [N_LEDS-1:0] leds;
   logic [6:0]        hex0;

   assign onehot = N_LEDS'(1) << pos;
   assign fill_w = ((N_LEDS + 1)'(1) << (pos + POS_W'(1))) - (N_LEDS + 1)'(1);

   always_comb begin
      leds = '0;
      hex0 = SEG_BLANK;
      unique case (1'b1)
         (mode == BOUNCE): begin
            leds = onehot;
            hex0 = SEG_0;
         end
         (mode == WRAP): begin
            leds = onehot;
            hex0 = SEG_1;
         end
         (mode == FILL): begin
            leds = fill_w[N_LEDS-1:0];
            hex0 = SEG_2;
         end
         default: begin
            leds = {N_LEDS{phase}};
            hex0 = SEG_3;
         end
      endcase
   end

   assign io.LEDR = leds;
   assign io.HEX0 = hex0;
   assign io.HEX1 = (run == PAUSE) ? SEG_P : SEG_BLANK;

   logic unused_ok;
   assign unused_ok = ^{io.SW[9:3], press[2], fill_w[N_LEDS]};

endmodule

// File: tb/tb_light_show_controller.sv
// Directed bench for light_show_controller, TICK_BASE=2, N_LEDS=10.
// Inputs change and outputs are checked on the falling clock edge.
module tb_light_show_controller;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   light_show_controller_if #(.N_LEDS(10)) io ();

   light_show_controller #(
      .TICK_BASE (2),
      .N_LEDS    (10)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .io       (io)
   );

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] SP = 7'b0001100;
   localparam logic [6:0] SB = 7'b1111111;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Keys in mask held low for one clock; ends on the negedge just
   // after the resulting state update.
   task automatic press(input logic [3:0] mask);
      io.KEY = ~mask;
      @(negedge clk);
      io.KEY = 4'hF;
      wait_n(2);
   endtask

   initial begin
      logic [15:0] e;
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      io.KEY = 4'hF;
      io.SW  = 10'd0;
      wait_n(3);
      chk("rst_ledr", 16'(io.LEDR), 16'h001);
      chk("rst_hex0", 16'(io.HEX0), 16'(S0));
      chk("rst_hex1", 16'(io.HEX1), 16'(SB));
      reset = 1'b0;

      // Bounce walk 0..9..0, one step every 4 clocks.
      wait_n(3);
      chk("first_step_early", 16'(io.LEDR), 16'h001);
      wait_n(1);
      chk("bounce_1", 16'(io.LEDR), 16'h002);
      for (int i = 2; i <= 19; i++) begin
         wait_n(4);
         e = (i <= 9) ? (16'h1 << i) :
             (i <= 18) ? (16'h1 << (18 - i)) : 16'h002;
         chk($sformatf("bounce_%0d", i), 16'(io.LEDR), e);
      end

      // Slow speed with restart, then speed change mid-period.
      io.SW = 10'd3;
      press(4'b1000);
      chk("restart_ledr", 16'(io.LEDR), 16'h001);
      wait_n(15);
      chk("sw3_hold", 16'(io.LEDR), 16'h001);
      wait_n(1);
      chk("sw3_step", 16'(io.LEDR), 16'h002);
      wait_n(9);
      io.SW = 10'd0;
      wait_n(2);
      chk("sw_chg_hold", 16'(io.LEDR), 16'h002);
      wait_n(1);
      chk("sw_chg_step", 16'(io.LEDR), 16'h004);

      // Held key gives exactly one increment; release gives none.
      io.KEY = 4'b1110;
      wait_n(50);
      chk("hold_mode1", 16'(io.HEX0), 16'(S1));
      io.KEY = 4'hF;
      wait_n(5);
      chk("release_mode1", 16'(io.HEX0), 16'(S1));
      press(4'b0001);
      chk("mode2", 16'(io.HEX0), 16'(S2));
      press(4'b0001);
      chk("mode3", 16'(io.HEX0), 16'(S3));
      press(4'b0001);
      chk("mode_wrap0", 16'(io.HEX0), 16'(S0));

      // Fill mode.
      press(4'b0001);
      press(4'b0001);
      chk("fill_hex0", 16'(io.HEX0), 16'(S2));
      chk("fill_0", 16'(io.LEDR), 16'h001);
      for (int i = 1; i <= 10; i++) begin
         wait_n(4);
         e = (16'h1 << ((i % 10) + 1)) - 16'h1;
         chk($sformatf("fill_%0d", i), 16'(io.LEDR), e);
      end

      // Blink mode.
      press(4'b0001);
      chk("blink_0", 16'(io.LEDR), 16'h3FF);
      for (int i = 1; i <= 4; i++) begin
         wait_n(4);
         e = (i % 2 == 1) ? 16'h000 : 16'h3FF;
         chk($sformatf("blink_%0d", i), 16'(io.LEDR), e);
      end

      // Pause and resume keep pos and the partial tick count.
      press(4'b0001);
      chk("bounce_again", 16'(io.LEDR), 16'h001);
      wait_n(4);
      chk("pre_pause", 16'(io.LEDR), 16'h002);
      press(4'b0010);
      chk("pause_hex1", 16'(io.HEX1), 16'(SP));
      wait_n(100);
      chk("pause_frozen", 16'(io.LEDR), 16'h002);
      press(4'b0010);
      chk("resume_hex1", 16'(io.HEX1), 16'(SB));
      chk("resume_ledr", 16'(io.LEDR), 16'h002);
      wait_n(1);
      chk("resume_step", 16'(io.LEDR), 16'h004);

      // Restart landing on a step edge drops the step.
      wait_n(1);
      press(4'b1000);
      chk("restart_on_step", 16'(io.LEDR), 16'h001);
      wait_n(3);
      chk("restart_full_hold", 16'(io.LEDR), 16'h001);
      wait_n(1);
      chk("restart_full_step", 16'(io.LEDR), 16'h002);

      // Reset mid-bounce at pos 7 heading down.
      wait_n(40);
      chk("pos7_down", 16'(io.LEDR), 16'h080);
      reset = 1'b1;
      wait_n(1);
      chk("midrst_ledr", 16'(io.LEDR), 16'h001);
      chk("midrst_hex0", 16'(io.HEX0), 16'(S0));
      reset = 1'b0;
      wait_n(4);
      chk("midrst_dir_up", 16'(io.LEDR), 16'h002);

      // KEY0+KEY1+KEY3 together: one mode step, paused, pattern reset.
      press(4'b1011);
      chk("combo_hex0", 16'(io.HEX0), 16'(S1));
      chk("combo_hex1", 16'(io.HEX1), 16'(SP));
      chk("combo_ledr", 16'(io.LEDR), 16'h001);
      wait_n(20);
      chk("combo_frozen", 16'(io.LEDR), 16'h001);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
